// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction ROM, captures the returned word into the IR and offers it
// to decode over a valid/ready handshake. Supports stall, branch redirect
// with flush, halt/resume, and a saturating count of IR loads.
module instruction_fetch #(
  parameter int unsigned                     WIDTH         = 32,
  parameter int unsigned                     ROM_ADDR_BITS = 12,
  parameter logic [ROM_ADDR_BITS-1:0]        RESET_VECTOR  = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [ROM_ADDR_BITS-1:0] PCadr,
  input  logic [WIDTH-1:0]         rom_instruction,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [ROM_ADDR_BITS-1:0] branch_target,
  input  logic                     halt,
  input  logic                     resume,
  input  logic                     dec_ready,
  output logic [WIDTH-1:0]         ir,
  output logic [ROM_ADDR_BITS-1:0] ir_pc,
  output logic                     ir_valid,
  output logic                     halted,
  output logic [15:0]              fetch_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ROM_ADDR_BITS-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]         ir_q, ir_d;
  logic [ROM_ADDR_BITS-1:0] ir_pc_q, ir_pc_d;
  logic                     ir_valid_q, ir_valid_d;
  logic                     halted_q, halted_d;
  logic [15:0]              fetch_count_q, fetch_count_d;
  logic                     load_s;
  logic                     redirect_s;
  logic                     transfer_s;

  // Saturating increment for the fetch counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      sat_inc16 = 16'hFFFF;
    end else begin
      sat_inc16 = val + 16'd1;
    end
  endfunction

  // Handshake qualifiers: redirect wins over everything; BOOT ignores it.
  always_comb begin
    transfer_s = ir_valid_q & dec_ready;
    redirect_s = branch_taken & ((state_q == ST_RUN) | (state_q == ST_HALT));
    load_s     = (state_q == ST_RUN) & ~halt & ~stall & ~branch_taken &
                 (~ir_valid_q | dec_ready);
  end

  // FSM next state: BOOT lasts one cycle, halt wins over a concurrent resume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume && !halt) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // Datapath next state: redirect/flush, load, or drain of a consumed IR.
  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;
    if (redirect_s) begin
      pc_d       = branch_target;
      ir_valid_d = 1'b0;
    end else if (load_s) begin
      ir_d          = rom_instruction;
      ir_pc_d       = pc_q;
      ir_valid_d    = 1'b1;
      pc_d          = pc_q + ROM_ADDR_BITS'(1);
      fetch_count_d = sat_inc16(fetch_count_q);
    end else if (transfer_s) begin
      ir_valid_d = 1'b0;
    end else begin
      ir_valid_d = ir_valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign PCadr       = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a combinational ROM model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic [11:0] pc_adr;
  logic [31:0] rom_instruction;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        halt;
  logic        resume;
  logic        dec_ready;
  logic [31:0] ir;
  logic [11:0] ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PCadr           (pc_adr),
    .rom_instruction (rom_instruction),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .halt            (halt),
    .resume          (resume),
    .dec_ready       (dec_ready),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  // ROM contents: tag byte, address, inverted address.
  function automatic logic [31:0] rom_word(input logic [11:0] a);
    rom_word = {8'hA0, a, ~a};
  endfunction

  assign rom_instruction = rom_word(pc_adr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle to the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ir(input string tag, input logic [11:0] pc, input logic [15:0] cnt);
    check({tag, "_ir"}, ir, rom_word(pc));
    check({tag, "_irpc"}, 32'(ir_pc), 32'(pc));
    check({tag, "_valid"}, 32'(ir_valid), 32'd1);
    check({tag, "_cnt"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 12'd0;
    halt = 1'b0; resume = 1'b0; dec_ready = 1'b1;
    #12;
    check("rst_pc", 32'(pc_adr), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cnt", 32'(fetch_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // BOOT cycle: no load, PC held.
    step();
    check("boot_valid", 32'(ir_valid), 32'd0);
    check("boot_pc", 32'(pc_adr), 32'd0);

    // Streaming loads from address 0.
    step(); check_ir("run0", 12'd0, 16'd1);
    step(); check_ir("run1", 12'd1, 16'd2);
    step(); check_ir("run2", 12'd2, 16'd3);
    check("run2_pc", 32'(pc_adr), 32'd3);
    for (int i = 3; i <= 5; i++) step();
    check_ir("run5", 12'd5, 16'd6);

    // Backpressure holds IR and PC.
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_pc", 32'(pc_adr), 32'd6);
      check_ir("bp", 12'd5, 16'd6);
    end
    dec_ready = 1'b1;
    step(); check_ir("bp_rel", 12'd6, 16'd7);

    // Branch during stall.
    for (int i = 7; i <= 9; i++) step();
    check("pre_br_pc", 32'(pc_adr), 32'd10);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 12'h200;
    step();
    check("brst_pc", 32'(pc_adr), 32'h200);
    check("brst_valid", 32'(ir_valid), 32'd0);
    check("brst_irpc_stale", 32'(ir_pc), 32'd9);
    check("brst_cnt", 32'(fetch_count), 32'd10);
    stall = 1'b0; branch_taken = 1'b0;
    step(); check_ir("brst_after", 12'h200, 16'd11);

    // Wrap at the top of the address space.
    branch_taken = 1'b1; branch_target = 12'hFFE;
    step();
    check("wrap_br_pc", 32'(pc_adr), 32'hFFE);
    branch_taken = 1'b0;
    step(); check_ir("wrap0", 12'hFFE, 16'd12);
    step(); check_ir("wrap1", 12'hFFF, 16'd13);
    step(); check_ir("wrap2", 12'h000, 16'd14);
    check("wrap_pc", 32'(pc_adr), 32'd1);

    // Halt / resume at PC 7.
    branch_taken = 1'b1; branch_target = 12'd7;
    step();
    branch_taken = 1'b0; halt = 1'b1;
    step();
    check("halt_h", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc_adr), 32'd7);
    check("halt_valid", 32'(ir_valid), 32'd0);
    step(); step();
    check("halt_hold_pc", 32'(pc_adr), 32'd7);
    check("halt_hold_cnt", 32'(fetch_count), 32'd14);
    resume = 1'b1;
    step();
    check("halt_both", 32'(halted), 32'd1);
    check("halt_both_cnt", 32'(fetch_count), 32'd14);
    halt = 1'b0;
    step();
    check("resume_h", 32'(halted), 32'd0);
    check("resume_noload", 32'(ir_valid), 32'd0);
    resume = 1'b0;
    step(); check_ir("resume_ld", 12'd7, 16'd15);

    // Stall with a consuming decode clears valid, holds IR.
    stall = 1'b1;
    step();
    check("stall_valid", 32'(ir_valid), 32'd0);
    check("stall_pc", 32'(pc_adr), 32'd8);
    check("stall_irpc", 32'(ir_pc), 32'd7);
    stall = 1'b0;
    step(); check_ir("post_stall", 12'd8, 16'd16);

    // Reset asserted mid-HALT with a pending IR.
    dec_ready = 1'b0; halt = 1'b1;
    step();
    check("h2_halted", 32'(halted), 32'd1);
    check("h2_valid", 32'(ir_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mrst_pc", 32'(pc_adr), 32'd0);
    check("mrst_ir", ir, 32'd0);
    check("mrst_irpc", 32'(ir_pc), 32'd0);
    check("mrst_valid", 32'(ir_valid), 32'd0);
    check("mrst_halted", 32'(halted), 32'd0);
    check("mrst_cnt", 32'(fetch_count), 32'd0);
    @(negedge clk);
    halt = 1'b0; dec_ready = 1'b1;
    reset_n = 1'b1;
    step();

    // Saturation of the fetch counter.
    for (int i = 0; i < 65534; i++) step();
    check("sat_pre", 32'(fetch_count), 32'hFFFE);
    step();
    check("sat_max", 32'(fetch_count), 32'hFFFF);
    step(); step();
    check("sat_hold", 32'(fetch_count), 32'hFFFF);
    check("sat_valid", 32'(ir_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the 12-bit word address to the ROM.
- Captures the returned 32-bit word into an instruction register (IR) and hands it to decode over a valid/ready handshake.
- Handles stall, branch redirect/flush, halt/resume, and keeps a saturating fetch counter.

Parameters:
- WIDTH, 32, instruction word width.
- ROM_ADDR_BITS, 12, PC/word-address width (4096 words).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PCadr  out  ROM_ADDR_BITS  word address to ROM; equals the PC register.
- rom_instruction  in  WIDTH  ROM data for PCadr, valid in the same cycle (combinational).
- stall  in  1  hold PC and IR this cycle.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  ROM_ADDR_BITS  redirect word address.
- halt  in  1  request to stop fetching.
- resume  in  1  leave halt.
- dec_ready  in  1  decode accepts IR this cycle.
- ir  out  WIDTH  instruction register.
- ir_pc  out  ROM_ADDR_BITS  address the IR word came from.
- ir_valid  out  1  IR holds an unconsumed instruction.
- halted  out  1  FSM is in HALT.
- fetch_count  out  16  number of IR loads, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - PC=RESET_VECTOR, ir=0, ir_pc=0, ir_valid=0, fetch_count=0, halted=0, state=BOOT.
  - Reset mid-operation discards any IR contents immediately.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts one cycle after reset_n deasserts; no load, PC held; then -> RUN unconditionally. branch_taken and halt are ignored in BOOT.
  - RUN: fetch per the rules below. halt=1 -> HALT at the next edge; no load occurs in the cycle halt is sampled.
  - HALT: no loads. resume=1 and halt=0 -> RUN. If halt and resume are both 1, stay in HALT.
- Transfer to decode: occurs on an edge where ir_valid=1 and dec_ready=1.
- Load enable: load = (state==RUN) & !halt & !stall & !branch_taken & (!ir_valid | dec_ready).
- On load:
  - ir <= rom_instruction, ir_pc <= PC, ir_valid <= 1.
  - PC <= PC+1, modulo 2^ROM_ADDR_BITS (4095 -> 0 wraps silently).
  - fetch_count <= fetch_count+1, saturating at 0xFFFF.
- Consumed but not loaded: ir_valid=1, dec_ready=1 and no load -> ir_valid <= 0. ir and ir_pc hold their values.
- Backpressure: ir_valid=1 and dec_ready=0 -> ir, ir_pc and PC all hold, even when stall=0.
- Stall: stall=1 and branch_taken=0 -> PC holds and no load. A transfer may still complete, which clears ir_valid.
- Branch redirect (RUN or HALT):
  - branch_taken=1 has priority over stall, halt and load.
  - PC <= branch_target, ir_valid <= 0 (flush); ir and ir_pc keep stale values; fetch_count is unchanged.
  - In HALT, the FSM stays in HALT with the updated PC.
- Latency: an address presented on PCadr in cycle N appears on ir/ir_valid after the edge ending cycle N. Steady-state throughput is 1 instruction/cycle with dec_ready held high.
- Outputs: all registered except PCadr, which is a direct copy of the PC register. halted = (state==HALT).

Test Plan:
- Reset release, dec_ready=1, ROM[0..3]=A0,A1,A2,A3 -> no load in BOOT; then ir=A0/ir_pc=0, A1/1, A2/2 on consecutive cycles; fetch_count=3 after three loads.
- Backpressure: ir_valid=1, ir_pc=5, dec_ready=0 for 3 cycles -> PCadr stays 6 and ir unchanged; dec_ready=1 -> ir_pc=6 next edge.
- Branch during stall: PC=10, stall=1, branch_taken=1, target=0x200 -> next edge PCadr=0x200, ir_valid=0; following cycle (stall=0) ir_pc=0x200.
- Wrap: branch to 0xFFE, run 3 loads -> ir_pc sequence 0xFFE, 0xFFF, 0x000; PCadr=0x001.
- Halt/resume: halt=1 at PC=7 -> halted=1 next edge, no further loads; halt=1 & resume=1 -> stays halted; resume=1 alone -> RUN, next load gives ir_pc=7. reset_n=0 asserted mid-HALT -> all outputs at reset values immediately.
- Saturation: preload 65534 loads (or force counter) then 3 more loads -> fetch_count=0xFFFF, held.
